mem_wb_pipe_stage: RTL and testbench
====================================

# mem_wb_pipe_stage

Parametrised MEM/WB pipeline stage with a valid/ready handshake, a two-entry skid buffer, flush, and a sticky halt. It carries write-back control plus three data channels (ALU result, memory read data, next PC) from the memory stage to the register-file write port. It selects the write-back value itself, so the register file sees a single `out_wb_data` bus. It replaces the fixed 16-bit, enable-only MEM/WB register in the pipelined processor.

## Interface
- `DATA_W`, default 16: width of each data channel.
- `REG_ADDR_W`, default 4: destination register address width.
- `ZERO_REG_RO`, default 1: when 1, a write to register 0 is suppressed at the output.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all buffered entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept; depends on registers only.
- `in_hlt`, `in_mem_to_reg`, `in_reg_write`, `in_pcs`  in  1 each  control bits.
- `in_write_reg`  in  REG_ADDR_W  destination register.
- `in_alu_out`, `in_mem_data`, `in_next_pc`  in  DATA_W each  data channels.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer takes head.
- `out_hlt`, `out_mem_to_reg`, `out_reg_write`, `out_pcs`, `out_write_reg`, `out_alu_out`, `out_mem_data`, `out_next_pc`  out  head-entry fields.
- `out_wb_data`  out  DATA_W  selected write-back value.
- `halted`  out  1  sticky; a halt entry has retired.
- `occupancy`  out  2  number of entries held (0..2).

## Operation
- Storage: two entries, head (H) and skid (S), each holding the full field set. `occupancy` is the count of valid entries. S is valid only if H is valid.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (occupancy != 2) && !halt_pending && !halted`.
- `out_valid = (occupancy != 0)`. All `out_*` fields come from H.
- Per-cycle updates, with no flush:
  - Push only: the entry goes to H if occupancy is 0, otherwise to S.
  - Pop only: S moves to H and occupancy decrements.
  - Push and pop at occupancy 1: the new entry goes to H and occupancy stays 1.
  - Push and pop at occupancy 2: cannot occur, because `in_ready` is 0.
- Flush:
  - Occupancy goes to 0 next cycle and `halt_pending` clears.
  - A same-cycle push is dropped. A same-cycle pop is a legal handshake (the consumer may take H) but does not set `halted`.
  - `halted` is not cleared by flush.
- Halt:
  - Accepting an entry with `in_hlt=1` sets `halt_pending`, and `in_ready` goes to 0 from the next cycle.
  - When that entry pops, `halted` sets and `halt_pending` clears.
  - Only reset clears `halted`.
- Write-back select, combinational from H:
  - `out_mem_to_reg=1` gives `out_mem_data`.
  - Otherwise `out_pcs=1` gives `out_next_pc`.
  - Otherwise it gives `out_alu_out`.
  - `out_mem_to_reg` has priority over `out_pcs`.
- `out_reg_write` = H.reg_write && out_valid && !(ZERO_REG_RO && H.write_reg == 0).
- Contents of an empty entry are don't-care, but every `out_*` field resets to 0.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - All entries zeroed, occupancy 0.
  - `out_valid`=0, `halted`=0, `halt_pending`=0.
  - `in_ready`=1, `out_wb_data`=0, `occupancy`=0.
- Reset released mid-stream: stage is empty; upstream must re-present.
- Latency: a push into an empty stage appears at the outputs the next cycle.
- Throughput: one entry per cycle with `out_ready` held at 1.
- A push at cycle t with `out_ready` low raises occupancy in cycle t+1. `in_ready` falls in cycle t+1 only when occupancy reaches 2.
- `in_ready` has no combinational path from `out_ready`, `in_valid`, or `flush`.
- `halted` rises in the cycle after the halt entry's pop handshake.

## Test plan
- Stream: push A=0x1111, then B=0x2222, then C=0x3333 (alu_out, reg_write=1, write_reg=3) in consecutive cycles with `out_ready`=1 -> each appears 1 cycle later with `out_wb_data` equal to its value; occupancy never exceeds 1.
- Backpressure: hold `out_ready`=0 and offer 3 entries -> occupancy 1, then 2. `in_ready`=0 after the second entry and the third is not accepted. Release `out_ready` -> the two held entries drain in order, and `in_ready` returns to 1 one cycle after the first pop.
- Select and priority:
  - mem_to_reg=1, pcs=1, mem_data=0xBEEF, next_pc=0x0042 -> `out_wb_data`=0xBEEF.
  - mem_to_reg=0, pcs=1 -> 0x0042.
  - Both control bits 0 -> alu_out.
- Zero register: reg_write=1, write_reg=0 -> `out_reg_write`=0 with ZERO_REG_RO=1, and 1 with ZERO_REG_RO=0.
- Halt and flush:
  - Push hlt=1 -> `in_ready`=0 next cycle; its pop sets `halted` the following cycle.
  - Separately, push hlt=1 then flush before its pop -> occupancy 0, `halted`=0, `in_ready`=1.
  - `halted` stays 1 across a later flush and clears only when `rst` is driven low.
- Asynchronous reset at occupancy 2 -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline stage: two-entry skid buffer with a valid/ready handshake, flush, sticky halt,
// and a write-back select that drives a single value to the register-file write port.
module mem_wb_pipe_stage #(
    parameter int DATA_W      = 16,
    parameter int REG_ADDR_W  = 4,
    parameter bit ZERO_REG_RO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_hlt,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    input  logic                  in_pcs,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic [DATA_W-1:0]     in_alu_out,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_next_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_hlt,
    output logic                  out_mem_to_reg,
    output logic                  out_reg_write,
    output logic                  out_pcs,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic [DATA_W-1:0]     out_alu_out,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [DATA_W-1:0]     out_next_pc,
    output logic [DATA_W-1:0]     out_wb_data,
    output logic                  halted,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic                  hlt;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  pcs;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [DATA_W-1:0]     alu_out;
        logic [DATA_W-1:0]     mem_data;
        logic [DATA_W-1:0]     next_pc;
    } entry_t;

    entry_t     h_q, h_d;
    entry_t     s_q, s_d;
    entry_t     in_entry;
    logic [1:0] occ_q, occ_d;
    logic       halt_pending_q, halt_pending_d;
    logic       halted_q, halted_d;
    logic       push;
    logic       pop;

    assign in_entry = '{
        hlt:        in_hlt,
        mem_to_reg: in_mem_to_reg,
        reg_write:  in_reg_write,
        pcs:        in_pcs,
        write_reg:  in_write_reg,
        alu_out:    in_alu_out,
        mem_data:   in_mem_data,
        next_pc:    in_next_pc
    };

    // Ready is a function of registered state only, so it never loops back through the handshake.
    assign in_ready  = (occ_q != 2'd2) && !halt_pending_q && !halted_q;
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        h_d            = h_q;
        s_d            = s_q;
        occ_d          = occ_q;
        halt_pending_d = halt_pending_q;
        halted_d       = halted_q;
        if (flush) begin
            // A pop in the flush cycle is still a legal handshake but never retires a halt.
            occ_d          = 2'd0;
            halt_pending_d = 1'b0;
        end else begin
            if (push && pop) begin
                h_d = in_entry;
            end else if (push) begin
                if (occ_q == 2'd0) begin
                    h_d = in_entry;
                end else begin
                    s_d = in_entry;
                end
                occ_d = occ_q + 2'd1;
            end else if (pop) begin
                h_d   = s_q;
                occ_d = occ_q - 2'd1;
            end
            if (push && in_hlt) begin
                halt_pending_d = 1'b1;
            end
            if (pop && h_q.hlt) begin
                halted_d       = 1'b1;
                halt_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q            <= '0;
            s_q            <= '0;
            occ_q          <= 2'd0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            h_q            <= h_d;
            s_q            <= s_d;
            occ_q          <= occ_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
        end
    end

    assign out_hlt        = h_q.hlt;
    assign out_mem_to_reg = h_q.mem_to_reg;
    assign out_pcs        = h_q.pcs;
    assign out_write_reg  = h_q.write_reg;
    assign out_alu_out    = h_q.alu_out;
    assign out_mem_data   = h_q.mem_data;
    assign out_next_pc    = h_q.next_pc;
    assign out_reg_write  = h_q.reg_write && out_valid
                            && !(ZERO_REG_RO && (h_q.write_reg == '0));
    // Memory data wins over the link PC when both selects are set.
    assign out_wb_data    = h_q.mem_to_reg ? h_q.mem_data :
                            h_q.pcs        ? h_q.next_pc  : h_q.alu_out;
    assign halted         = halted_q;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: table-driven handshake vectors, hand-written halt/flush/reset
// sequences, and a scoreboard that checks every popped entry in order.
module tb_mem_wb_pipe_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid, in_ready;
    logic        in_hlt, in_mem_to_reg, in_reg_write, in_pcs;
    logic [3:0]  in_write_reg;
    logic [15:0] in_alu_out, in_mem_data, in_next_pc;
    logic        out_valid, out_ready;
    logic        out_hlt, out_mem_to_reg, out_reg_write, out_pcs;
    logic [3:0]  out_write_reg;
    logic [15:0] out_alu_out, out_mem_data, out_next_pc, out_wb_data;
    logic        halted;
    logic [1:0]  occupancy;

    // Second instance with register 0 writable; shares all inputs.
    logic        b_in_ready, b_out_valid, b_out_hlt, b_out_m2r, b_out_reg_write, b_out_pcs;
    logic [3:0]  b_out_write_reg;
    logic [15:0] b_out_alu, b_out_mem, b_out_npc, b_out_wb;
    logic        b_halted;
    logic [1:0]  b_occ;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_pipe_stage #(.DATA_W(16), .REG_ADDR_W(4), .ZERO_REG_RO(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_hlt(in_hlt), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_pcs(in_pcs), .in_write_reg(in_write_reg),
        .in_alu_out(in_alu_out), .in_mem_data(in_mem_data), .in_next_pc(in_next_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hlt(out_hlt), .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_pcs(out_pcs), .out_write_reg(out_write_reg),
        .out_alu_out(out_alu_out), .out_mem_data(out_mem_data), .out_next_pc(out_next_pc),
        .out_wb_data(out_wb_data), .halted(halted), .occupancy(occupancy)
    );

    mem_wb_pipe_stage #(.DATA_W(16), .REG_ADDR_W(4), .ZERO_REG_RO(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_hlt(in_hlt), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_pcs(in_pcs), .in_write_reg(in_write_reg),
        .in_alu_out(in_alu_out), .in_mem_data(in_mem_data), .in_next_pc(in_next_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_hlt(b_out_hlt), .out_mem_to_reg(b_out_m2r), .out_reg_write(b_out_reg_write),
        .out_pcs(b_out_pcs), .out_write_reg(b_out_write_reg),
        .out_alu_out(b_out_alu), .out_mem_data(b_out_mem), .out_next_pc(b_out_npc),
        .out_wb_data(b_out_wb), .halted(b_halted), .occupancy(b_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] wb;
        logic [3:0]  wr;
        logic        rw_ro;
        logic        rw_raw;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    // Scoreboard: compare head on each pop handshake, then record an accepted push.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        if (!rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_empty_sb: got wb 0x%0h, expected no entry", out_wb_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", {16'h0, out_wb_data}, {16'h0, e.wb});
                    chk("write_reg", {28'h0, out_write_reg}, {28'h0, e.wr});
                    chk("reg_write_ro", {31'h0, out_reg_write}, {31'h0, e.rw_ro});
                    chk("reg_write_rw", {31'h0, b_out_reg_write}, {31'h0, e.rw_raw});
                    chk("out_hlt", {31'h0, out_hlt}, {31'h0, e.hlt});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                n.wb     = in_mem_to_reg ? in_mem_data : (in_pcs ? in_next_pc : in_alu_out);
                n.wr     = in_write_reg;
                n.rw_ro  = in_reg_write && (in_write_reg != 4'd0);
                n.rw_raw = in_reg_write;
                n.hlt    = in_hlt;
                sb.push_back(n);
            end
        end
    end

    typedef struct {
        logic        v;
        logic        hlt;
        logic        m2r;
        logic        pcs;
        logic        rw;
        logic [3:0]  wr;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [15:0] npc;
        logic        ordy;
        logic        fl;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    function automatic vec_t mk(logic v, logic m2r, logic pcs, logic rw, logic [3:0] wr,
                                logic [15:0] alu, logic [15:0] mem, logic [15:0] npc,
                                logic ordy, logic [1:0] e_occ, logic e_ir);
        vec_t r;
        r.v = v; r.hlt = 1'b0; r.m2r = m2r; r.pcs = pcs; r.rw = rw; r.wr = wr;
        r.alu = alu; r.mem = mem; r.npc = npc; r.ordy = ordy; r.fl = 1'b0;
        r.e_occ = e_occ; r.e_ir = e_ir;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        in_valid = x.v; in_hlt = x.hlt; in_mem_to_reg = x.m2r; in_pcs = x.pcs;
        in_reg_write = x.rw; in_write_reg = x.wr; in_alu_out = x.alu;
        in_mem_data = x.mem; in_next_pc = x.npc; out_ready = x.ordy; flush = x.fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];
    vec_t h;

    initial begin
        vecs[0]  = mk(1, 0, 0, 1, 4'd3, 16'h1111, 16'h0, 16'h0, 1, 2'd1, 1);
        vecs[1]  = mk(1, 0, 0, 1, 4'd3, 16'h2222, 16'h0, 16'h0, 1, 2'd1, 1);
        vecs[2]  = mk(1, 0, 0, 1, 4'd3, 16'h3333, 16'h0, 16'h0, 1, 2'd1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 4'd0, 16'h0,    16'h0, 16'h0, 1, 2'd0, 1);
        vecs[4]  = mk(1, 0, 0, 1, 4'd5, 16'h4444, 16'h0, 16'h0, 0, 2'd1, 1);
        vecs[5]  = mk(1, 0, 0, 1, 4'd6, 16'h5555, 16'h0, 16'h0, 0, 2'd2, 0);
        vecs[6]  = mk(1, 0, 0, 1, 4'd7, 16'h6666, 16'h0, 16'h0, 0, 2'd2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 4'd0, 16'h0,    16'h0, 16'h0, 1, 2'd1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 4'd0, 16'h0,    16'h0, 16'h0, 1, 2'd0, 1);
        vecs[9]  = mk(1, 1, 1, 1, 4'd2, 16'h0AAA, 16'hBEEF, 16'h0042, 1, 2'd1, 1);
        vecs[10] = mk(1, 0, 1, 1, 4'd2, 16'h0AAA, 16'hBEEF, 16'h0042, 1, 2'd1, 1);
        vecs[11] = mk(1, 0, 0, 1, 4'd2, 16'h1234, 16'hBEEF, 16'h0042, 1, 2'd1, 1);
        vecs[12] = mk(1, 0, 0, 1, 4'd0, 16'h7777, 16'h0,    16'h0,    1, 2'd1, 1);
        vecs[13] = mk(0, 0, 0, 0, 4'd0, 16'h0,    16'h0, 16'h0, 1, 2'd0, 1);

        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 2'd0, 1));
        #2;
        chk("rst_occ", {30'h0, occupancy}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_wb_data", {16'h0, out_wb_data}, 32'd0);
        step();
        step();
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("vec%0d_occ", i), {30'h0, occupancy}, {30'h0, vecs[i].e_occ});
            chk($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {31'h0, out_valid},
                {31'h0, (vecs[i].e_occ != 2'd0)});
        end

        // Halt retires on pop; halted survives flush and clears on reset.
        h = mk(1, 0, 0, 1, 4'd1, 16'h00F0, 16'h0, 16'h0, 0, 2'd1, 0);
        h.hlt = 1'b1;
        drive(h);
        step();
        chk("hlt_in_ready", {31'h0, in_ready}, 32'd0);
        chk("hlt_occ", {30'h0, occupancy}, 32'd1);
        chk("hlt_halted_early", {31'h0, halted}, 32'd0);
        drive(mk(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 1, 2'd0, 0));
        step();
        chk("hlt_halted", {31'h0, halted}, 32'd1);
        chk("hlt_occ_after_pop", {30'h0, occupancy}, 32'd0);
        chk("hlt_in_ready_after", {31'h0, in_ready}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("hlt_flush_halted", {31'h0, halted}, 32'd1);
        chk("hlt_flush_in_ready", {31'h0, in_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("hlt_rst_halted", {31'h0, halted}, 32'd0);
        chk("hlt_rst_in_ready", {31'h0, in_ready}, 32'd1);
        step();
        rst = 1'b1;

        // Halt entry flushed before its pop never sets halted.
        h.ordy = 1'b0;
        drive(h);
        step();
        chk("hflush_in_ready_pend", {31'h0, in_ready}, 32'd0);
        drive(mk(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 2'd0, 1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("hflush_occ", {30'h0, occupancy}, 32'd0);
        chk("hflush_halted", {31'h0, halted}, 32'd0);
        chk("hflush_in_ready", {31'h0, in_ready}, 32'd1);

        // Asynchronous reset with both entries full.
        drive(mk(1, 0, 0, 1, 4'd3, 16'h9999, 16'h0, 16'h0, 0, 2'd1, 1));
        step();
        drive(mk(1, 0, 0, 1, 4'd4, 16'hAAAA, 16'h0, 16'h0, 0, 2'd2, 0));
        step();
        chk("ar_occ_full", {30'h0, occupancy}, 32'd2);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("ar_occ", {30'h0, occupancy}, 32'd0);
        chk("ar_out_valid", {31'h0, out_valid}, 32'd0);
        chk("ar_in_ready", {31'h0, in_ready}, 32'd1);
        chk("ar_wb_data", {16'h0, out_wb_data}, 32'd0);
        chk("ar_reg_write", {31'h0, out_reg_write}, 32'd0);
        step();
        rst = 1'b1;
        step();

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
